addr22_seq: RTL and testbench

//  Sequencer for the 16-to-22-bit address datapath. A 16-bit host port loads a 22-bit base

---
 rtl/addr22_seq.sv | 121 ++++++++++++
 tb/tb_addr22_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr22_seq.sv
// Address burst sequencer: a 16-bit host port loads a wide base address and a beat
// count. START then streams COUNT addresses over a valid/ready handshake.
//
// state | meaning
// IDLE  | host writes accepted; waiting for START
// RUN   | presenting ADDR with ADDR_VALID; stepping on each accepted beat
module addr22_seq #(
    parameter int AW   = 22,
    parameter int DW   = 16,
    parameter int STEP = 1
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          WR_EN,
    input  logic [1:0]    WR_SEL,
    input  logic [DW-1:0] WR_DATA,
    input  logic          START,
    input  logic          ABORT,
    output logic [AW-1:0] ADDR,
    output logic          ADDR_VALID,
    input  logic          ADDR_READY,
    output logic          BUSY,
    output logic          DONE
);

    localparam int            HW     = AW - 16;
    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] remaining_q, remaining_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          done_q, done_d;

    logic          accept;
    logic [AW-1:0] addr_next;

    assign accept    = (state_q == RUN) && ADDR_READY;
    // The increment wraps naturally at the bus width; there is no carry-out.
    assign addr_next = addr_q + STEP_W;

    // State register and datapath flops; reset clears everything, dropping VALID at once.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: host writes, burst launch, beat stepping, completion and abort.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // START samples the registers before any same-cycle write lands.
                if (START) begin
                    if (count_q != '0) begin
                        state_d     = RUN;
                        addr_d      = base_q;
                        remaining_d = count_q;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                if (WR_EN) begin
                    case (WR_SEL)
                        2'd0:    base_d[15:0]    = WR_DATA[15:0];
                        2'd1:    base_d[AW-1:16] = WR_DATA[HW-1:0];
                        2'd2:    count_d         = WR_DATA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (accept) begin
                    addr_d      = addr_next;
                    remaining_d = remaining_q - DW'(1);
                end
                if (accept && (remaining_q == DW'(1))) begin
                    // Base becomes an auto-increment pointer for the next burst.
                    state_d = IDLE;
                    done_d  = 1'b1;
                    base_d  = addr_next;
                end else if (ABORT) begin
                    state_d = IDLE;
                    base_d  = accept ? addr_next : addr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ADDR       = addr_q;
    assign ADDR_VALID = (state_q == RUN);
    assign BUSY       = (state_q == RUN);
    assign DONE       = done_q;

endmodule

// File: tb/tb_addr22_seq.sv
// Bench for addr22_seq: a queue-based burst model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_addr22_seq;

    localparam int unsigned MASK = 32'h003F_FFFF;

    logic        CLK;
    logic        nRESET;
    logic        WR_EN;
    logic [1:0]  WR_SEL;
    logic [15:0] WR_DATA;
    logic        START;
    logic        ABORT;
    logic [21:0] ADDR;
    logic        ADDR_VALID;
    logic        ADDR_READY;
    logic        BUSY;
    logic        DONE;

    int n_tests = 0;
    int n_fail  = 0;

    addr22_seq dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .WR_EN      (WR_EN),
        .WR_SEL     (WR_SEL),
        .WR_DATA    (WR_DATA),
        .START      (START),
        .ABORT      (ABORT),
        .ADDR       (ADDR),
        .ADDR_VALID (ADDR_VALID),
        .ADDR_READY (ADDR_READY),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is a list of addresses base+i; beats pop it on acceptance.
    int unsigned m_base;
    int unsigned m_count;
    bit          m_active;
    bit          m_done;
    int unsigned m_q[$];

    initial begin
        int unsigned last;
        bit          nd;
        m_base = 0; m_count = 0; m_active = 0; m_done = 0;
        forever begin
            @(negedge CLK);
            if (!nRESET) begin
                m_base = 0; m_count = 0; m_active = 0; m_done = 0;
                m_q.delete();
                chk("rst_valid", {31'd0, ADDR_VALID}, 0);
                chk("rst_done", {31'd0, DONE}, 0);
            end else begin
                chk("m_valid", {31'd0, ADDR_VALID}, {31'd0, m_active});
                chk("m_busy", {31'd0, BUSY}, {31'd0, m_active});
                chk("m_done", {31'd0, DONE}, {31'd0, m_done});
                if (m_active && m_q.size() > 0)
                    chk("m_addr", {10'd0, ADDR}, m_q[0]);
                nd = 0;
                if (!m_active) begin
                    if (START) begin
                        if (m_count == 0) nd = 1;
                        else begin
                            m_q.delete();
                            for (int i = 0; i < int'(m_count); i++)
                                m_q.push_back((m_base + i) & MASK);
                            m_active = 1;
                        end
                    end
                    if (WR_EN) begin
                        case (WR_SEL)
                            2'd0: m_base = (m_base & 32'h003F_0000) | WR_DATA;
                            2'd1: m_base = (m_base & 32'h0000_FFFF) | ((WR_DATA & 32'h3F) << 16);
                            2'd2: m_count = WR_DATA;
                            default: ;
                        endcase
                    end
                end else begin
                    if (ADDR_READY && m_q.size() > 0) begin
                        last = m_q.pop_front();
                        if (m_q.size() == 0) begin
                            m_active = 0;
                            nd = 1;
                            m_base = (last + 1) & MASK;
                        end
                    end
                    if (m_active && ABORT) begin
                        m_active = 0;
                        m_base = m_q[0];
                        m_q.delete();
                    end
                end
                m_done = nd;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] data);
        WR_EN = 1'b1; WR_SEL = sel; WR_DATA = data;
        step();
        WR_EN = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] exp3 [4];
        int n;
        exp3[0] = 22'h3FFFFE; exp3[1] = 22'h3FFFFF; exp3[2] = 22'h000000; exp3[3] = 22'h000001;

        nRESET = 1'b0; WR_EN = 1'b0; WR_SEL = 2'd0; WR_DATA = 16'h0;
        START = 1'b0; ABORT = 1'b0; ADDR_READY = 1'b0;
        #2;
        chk("reset_addr", {10'd0, ADDR}, 0);
        chk("reset_valid", {31'd0, ADDR_VALID}, 0);
        chk("reset_busy", {31'd0, BUSY}, 0);
        chk("reset_done", {31'd0, DONE}, 0);
        step(); step();
        nRESET = 1'b1;
        step();

        // 1: three beats with READY high
        wr(2'd0, 16'h1234); wr(2'd1, 16'h002A); wr(2'd2, 16'd3);
        ADDR_READY = 1'b1;
        pulse_start();
        chk("t1_beat0", {10'd0, ADDR}, 32'h2A1234);
        chk("t1_valid", {31'd0, ADDR_VALID}, 1);
        step(); chk("t1_beat1", {10'd0, ADDR}, 32'h2A1235);
        step(); chk("t1_beat2", {10'd0, ADDR}, 32'h2A1236);
        step();
        chk("t1_done", {31'd0, DONE}, 1);
        chk("t1_idle", {31'd0, ADDR_VALID}, 0);
        step(); chk("t1_done_pulse", {31'd0, DONE}, 0);

        // 2: backpressure holds ADDR; base auto-incremented to 0x2A1237
        wr(2'd2, 16'd2);
        ADDR_READY = 1'b0;
        pulse_start();
        chk("t2_hold0", {10'd0, ADDR}, 32'h2A1237);
        step(); chk("t2_hold1", {10'd0, ADDR}, 32'h2A1237);
        step(); chk("t2_hold2", {10'd0, ADDR}, 32'h2A1237);
        ADDR_READY = 1'b1;
        step(); chk("t2_beat1", {10'd0, ADDR}, 32'h2A1238);
        step(); chk("t2_done", {31'd0, DONE}, 1);

        // 3: wrap at the top of the address space
        wr(2'd0, 16'hFFFE); wr(2'd1, 16'h003F); wr(2'd2, 16'd4);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("t3_wrap", {10'd0, ADDR}, {10'd0, exp3[i]});
            step();
        end
        chk("t3_done", {31'd0, DONE}, 1);

        // 4: zero-length burst
        wr(2'd2, 16'd0);
        pulse_start();
        chk("t4_valid", {31'd0, ADDR_VALID}, 0);
        chk("t4_busy", {31'd0, BUSY}, 0);
        chk("t4_done", {31'd0, DONE}, 1);
        step();
        chk("t4_done_pulse", {31'd0, DONE}, 0);

        // 5: same-cycle write+START, ignored writes/START in RUN, abort on the 4th beat
        wr(2'd0, 16'h0100); wr(2'd1, 16'h0005); wr(2'd2, 16'd10);
        WR_EN = 1'b1; WR_SEL = 2'd2; WR_DATA = 16'd7;
        pulse_start();
        WR_EN = 1'b0;
        chk("t5_beat0", {10'd0, ADDR}, 32'h050100);
        WR_EN = 1'b1; WR_SEL = 2'd0; WR_DATA = 16'hFFFF; START = 1'b1;
        step();
        WR_EN = 1'b0; START = 1'b0;
        chk("t5_beat1", {10'd0, ADDR}, 32'h050101);
        step(); chk("t5_beat2", {10'd0, ADDR}, 32'h050102);
        step(); chk("t5_beat3", {10'd0, ADDR}, 32'h050103);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("t5_abort_valid", {31'd0, ADDR_VALID}, 0);
        chk("t5_abort_busy", {31'd0, BUSY}, 0);
        chk("t5_abort_done", {31'd0, DONE}, 0);
        step(); chk("t5_no_done", {31'd0, DONE}, 0);
        pulse_start();
        chk("t5_resume", {10'd0, ADDR}, 32'h050104);
        n = 0;
        while (BUSY && n < 100) begin
            step();
            n++;
        end
        chk("t5_len", n, 7);
        chk("t5_done", {31'd0, DONE}, 1);

        // 6: asynchronous reset mid-burst, then a fresh burst from base 0
        step();
        pulse_start();
        step();
        #2 nRESET = 1'b0;
        #1;
        chk("t6_addr", {10'd0, ADDR}, 0);
        chk("t6_valid", {31'd0, ADDR_VALID}, 0);
        chk("t6_busy", {31'd0, BUSY}, 0);
        chk("t6_done", {31'd0, DONE}, 0);
        step();
        nRESET = 1'b1;
        step();
        wr(2'd2, 16'd2);
        pulse_start();
        chk("t6_beat0", {10'd0, ADDR}, 0);
        step(); chk("t6_beat1", {10'd0, ADDR}, 1);
        step(); chk("t6_fin", {31'd0, DONE}, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
